single_log_table: RTL and testbench
===================================

SINGLE_LOG_TABLE -- requirements
Module: single_log_table

Interface
REQ-001 Parameter BITS, 32, operand/result width; only 32 (IEEE-754 single) is legal.
REQ-002 Parameter STEPS, 64, ln table intervals over mantissa [1,2); power of 2, 16..1024.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  a carries a new operand this cycle.
REQ-006 a  input  BITS  IEEE-754 single operand x.
REQ-007 out_valid  output  1  c carries a result this cycle.
REQ-008 c  output  BITS  IEEE-754 single ln(x).

Function
REQ-009 Block SHALL compute c = ln(a), the inverse function of the team's single-precision exponent table, via table lookup plus linear interpolation.
REQ-010 Pipeline SHALL be exactly 4 stages, no stall: in_valid sampled at edge N gives out_valid=1 with its c after edge N+4; one result per cycle; results in input order.
REQ-011 out_valid SHALL be high only in cycles tied to a sampled in_valid; c is don't-care when out_valid=0.
REQ-012 Stage 1: unpack sign s, biased exponent E, mantissa M; k = top log2(STEPS) bits of M, f = remaining 23-log2(STEPS) bits; register T[k], T[k+1], f, e=E-127, special-case code.
REQ-013 Table T SHALL hold STEPS+1 entries T[i] = round(ln(1+i/STEPS)*2^32), unsigned Q0.32; T[0]=0, T[STEPS]=0xB17217F8; contents fixed at elaboration.
REQ-014 Stage 2: y = T[k] + (((T[k+1]-T[k]) * f) >> width(f)), truncating, unsigned Q0.32.
REQ-015 Stage 3: R = e*LN2 + y, LN2 = 0xB17217F8 (Q0.32), R signed 42-bit (sign, 9 int, 32 frac) with no overflow across e = -126..127.
REQ-016 Stage 4: sign = R<0; magnitude |R|; leading-one position p (0..40); exponent field = 127 + p - 32; mantissa = 23 bits below the leading one, truncated (zero-filled if fewer bits); R==0 gives 0x00000000.
REQ-017 Special cases SHALL bypass arithmetic and emerge with the same 4-cycle latency:
 - +0, -0, or any denormal (E=0) -> 0xFF800000 (-inf)
 - sign=1 with nonzero value (incl. -inf) -> 0x7FC00000
 - any NaN input -> 0x7FC00000
 - +inf (0x7F800000) -> 0x7F800000
REQ-018 Back-to-back operands of mixed normal/special class SHALL not interfere; each stage carries its own special code.
REQ-019 Accuracy for normal positive inputs: within 2^-20 absolute error for |ln x| < 1, else within 4 ulp of the correctly rounded result.

Reset
REQ-020 While reset=1, out_valid SHALL be 0 and every stage valid bit cleared; c SHALL reset to 0x00000000.
REQ-021 Reset asserted mid-stream SHALL discard all in-flight operands immediately (asynchronously); none emerge after release.
REQ-022 After reset deasserts, the first in_valid sampled at edge N SHALL produce out_valid after edge N+4; table contents are unaffected by reset.

Verification
REQ-023 a=0x3F800000 (1.0), single pulse -> exactly one out_valid 4 cycles later, c=0x00000000.
REQ-024 a=0x40000000 (2.0) -> c=0x3F317217; a=0x3F000000 (0.5) -> c=0xBF317217.
REQ-025 Specials back-to-back in consecutive cycles: 0x00000000, 0x80000000, 0xBF800000, 0x7FC00001, 0x7F800000 -> 0xFF800000, 0xFF800000, 0x7FC00000, 0x7FC00000, 0x7F800000 on 5 consecutive out_valid cycles.
REQ-026 Continuous in_valid=1 stream of 1000 random positive normals -> 1000 results in order, each within the REQ-019 error bound vs. a real-valued model, no gaps.
REQ-027 Issue 3 operands, assert reset for one cycle while they are in flight -> out_valid stays 0 throughout; the next operand after release gives its result 4 cycles later.
REQ-028 a=0x7F7FFFFF (max normal) -> c within 4 ulp of 0x42B17218; a=0x00800000 (min normal) -> c within 4 ulp of 0xC2AEAC50.

Source files
------------

// File: rtl/single_log_table_if.sv
// Operand/result stream bundle for the single-precision natural-log table.
// master drives operands, slave (the log block) returns results.
interface single_log_table_if #(
    parameter int BITS = 32
) ();
    logic            in_valid;
    logic [BITS-1:0] a;
    logic            out_valid;
    logic [BITS-1:0] c;

    modport master (output in_valid, a, input out_valid, c);
    modport slave  (input in_valid, a, output out_valid, c);
endinterface

// File: rtl/single_log_table.sv
// Single-precision c = ln(a): ln(mantissa) by table lookup plus linear interpolation,
// plus e*ln2, renormalised to IEEE-754. Operand capture rank then four pipelined stages.
module single_log_table #(
    parameter int BITS  = 32,
    parameter int STEPS = 64
) (
    input  logic              clk,
    input  logic              reset,
    single_log_table_if.slave bus
);
    localparam int KW = $clog2(STEPS);
    localparam int FW = 23 - KW;
    localparam logic signed [41:0] LN2 = 42'sh0_B172_17F8;

    typedef enum logic [1:0] {
        CODE_NORMAL,
        CODE_NEG_INF,
        CODE_QNAN,
        CODE_POS_INF
    } code_t;

    if (BITS != 32 || STEPS < 16 || STEPS > 1024 || (STEPS & (STEPS - 1)) != 0) begin : g_bad_param
        $error("single_log_table: BITS must be 32, STEPS a power of 2 in 16..1024");
    end

    // Table entry round(ln(1 + i/STEPS) * 2^32); the rounding is done by hand so it
    // does not depend on how the tool rounds a real-to-integer cast.
    function automatic logic [31:0] ln_entry(int unsigned i);
        real    r;
        longint v;
        r = $ln(1.0 + real'(i) / real'(STEPS)) * 4294967296.0;
        v = longint'(r);
        if (real'(v) - r > 0.5)
            v = v - 1;
        else if (r - real'(v) >= 0.5)
            v = v + 1;
        return v[31:0];
    endfunction

    logic [31:0] ln_table [STEPS+1];

    for (genvar gi = 0; gi <= STEPS; gi++) begin : g_tbl
        localparam logic [31:0] ENTRY = ln_entry(gi);
        assign ln_table[gi] = ENTRY;
    end

    logic              in_v;
    logic [31:0]       in_a;

    logic              s1_valid;
    code_t             s1_code;
    logic [31:0]       s1_t0;
    logic [31:0]       s1_t1;
    logic [FW-1:0]     s1_f;
    logic signed [8:0] s1_e;

    logic              s2_valid;
    code_t             s2_code;
    logic [31:0]       s2_y;
    logic signed [8:0] s2_e;

    logic               s3_valid;
    code_t              s3_code;
    logic signed [41:0] s3_r;

    logic        out_valid_q;
    logic [31:0] c_q;

    // Stage 1: unpack and classify
    code_t       d1_code;
    logic [KW:0] idx0;
    logic [KW:0] idx1;
    logic [7:0]  exp_f;
    logic [22:0] man_f;

    always_comb begin
        exp_f = in_a[30:23];
        man_f = in_a[22:0];
        idx0  = {1'b0, man_f[22 -: KW]};
        idx1  = idx0 + (KW+1)'(1);
        if (exp_f == 8'hFF)
            d1_code = (man_f != '0 || in_a[31]) ? CODE_QNAN : CODE_POS_INF;
        else if (exp_f == 8'h00)
            d1_code = CODE_NEG_INF;
        else if (in_a[31])
            d1_code = CODE_QNAN;
        else
            d1_code = CODE_NORMAL;
    end

    // Stage 2: interpolate
    logic [31:0]    diff;
    logic [31+FW:0] prod;
    logic [31:0]    d2_y;

    always_comb begin
        diff = s1_t1 - s1_t0;
        prod = (32+FW)'(diff) * (32+FW)'(s1_f);
        d2_y = s1_t0 + prod[31+FW:FW];
    end

    // Stage 3: add exponent contribution
    logic signed [41:0] e_ext;
    logic signed [41:0] d3_r;

    always_comb begin
        e_ext = {{33{s2_e[8]}}, s2_e};
        d3_r  = e_ext * LN2 + $signed({10'b0, s2_y});
    end

    // Stage 4: renormalise |R| (bit 32 is the units bit) into a float
    logic [41:0] mag;
    logic [5:0]  lead;
    logic [62:0] wide;
    logic [22:0] mant;
    logic [31:0] d4_c;

    always_comb begin
        mag  = s3_r[41] ? 42'(-s3_r) : 42'(s3_r);
        lead = '0;
        for (int unsigned i = 0; i < 41; i++)
            if (mag[i]) lead = 6'(i);
        wide = {mag[39:0], 23'b0};
        mant = 23'(wide >> lead);
        case (s3_code)
            CODE_NEG_INF: d4_c = 32'hFF80_0000;
            CODE_QNAN:    d4_c = 32'h7FC0_0000;
            CODE_POS_INF: d4_c = 32'h7F80_0000;
            default:      d4_c = (mag == '0) ? '0 : {s3_r[41], 8'(lead) + 8'd95, mant};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_v        <= 1'b0;
            in_a        <= '0;
            s1_valid    <= 1'b0;
            s1_code     <= CODE_NORMAL;
            s1_t0       <= '0;
            s1_t1       <= '0;
            s1_f        <= '0;
            s1_e        <= '0;
            s2_valid    <= 1'b0;
            s2_code     <= CODE_NORMAL;
            s2_y        <= '0;
            s2_e        <= '0;
            s3_valid    <= 1'b0;
            s3_code     <= CODE_NORMAL;
            s3_r        <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
        end else begin
            in_v        <= bus.in_valid;
            in_a        <= bus.a;

            s1_valid    <= in_v;
            s1_code     <= d1_code;
            s1_t0       <= ln_table[idx0];
            s1_t1       <= ln_table[idx1];
            s1_f        <= man_f[FW-1:0];
            s1_e        <= $signed({1'b0, exp_f}) - 9'sd127;

            s2_valid    <= s1_valid;
            s2_code     <= s1_code;
            s2_y        <= d2_y;
            s2_e        <= s1_e;

            s3_valid    <= s2_valid;
            s3_code     <= s2_code;
            s3_r        <= d3_r;

            out_valid_q <= s3_valid;
            if (s3_valid)
                c_q <= d4_c;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
endmodule

// File: tb/tb_single_log_table.sv
// Self-checking bench for single_log_table: directed vector table, reset corner cases,
// and a 1000-operand random stream checked against a real-valued ln model via a scoreboard.
module tb_single_log_table;
    localparam int STEPS = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    single_log_table_if #(.BITS(32)) bus ();

    single_log_table #(.BITS(32), .STEPS(STEPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // kind: 0 exact, 1 within 4 ulp of c_exp, 2 real-valued model
    typedef struct {
        logic [31:0] a;
        logic [31:0] c_exp;
        int          kind;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] c_exp;
        int          kind;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real pow2(int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real decode(logic [31:0] v);
        real m;
        if (v[30:0] == 31'd0) return 0.0;
        m = (1.0 + real'(v[22:0]) / 8388608.0) * pow2(int'(v[30:23]) - 127);
        return v[31] ? -m : m;
    endfunction

    task automatic check_out(input exp_t e, input logic [31:0] c);
        longint d;
        real    xm, refv, err, bound, mg;
        int     ex;
        checks++;
        if (cyc != e.due) begin
            errors++;
            $display("FAIL latency a=%h out_cycle=%0d required=%0d", e.a, cyc, e.due);
        end
        checks++;
        case (e.kind)
            0: if (c !== e.c_exp) begin
                errors++;
                $display("FAIL exact a=%h c=%h required=%h", e.a, c, e.c_exp);
            end
            1: begin
                d = longint'(c[30:0]) - longint'(e.c_exp[30:0]);
                if (c[31] !== e.c_exp[31] || d > 4 || d < -4) begin
                    errors++;
                    $display("FAIL ulp4 a=%h c=%h required=%h (+-4 ulp)", e.a, c, e.c_exp);
                end
            end
            default: begin
                xm   = 1.0 + real'(e.a[22:0]) / 8388608.0;
                refv = $ln(xm) + real'(int'(e.a[30:23]) - 127) * $ln(2.0);
                err  = decode(c) - refv;
                if (err < 0.0) err = -err;
                mg = (refv < 0.0) ? -refv : refv;
                if (mg < 1.0) bound = pow2(-20);
                else begin
                    ex = 0;
                    while (mg >= 2.0) begin mg = mg / 2.0; ex++; end
                    bound = 4.5 * pow2(ex - 23);
                end
                // linear interpolation of ln over 1/STEPS intervals sags by up to 1/(8*STEPS^2)
                bound = bound + 1.0 / (8.0 * real'(STEPS) * real'(STEPS)) + pow2(-28);
                if (err > bound) begin
                    errors++;
                    $display("FAIL model a=%h c=%h (%g) required ln=%g tol=%g", e.a, c, decode(c), refv, bound);
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_in_reset out_valid=%b required=0", bus.out_valid);
            end
        end else if (bus.out_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out c=%h cycle=%0d required=no output", bus.c, cyc);
            end else begin
                mon_e = sb.pop_front();
                check_out(mon_e, bus.c);
            end
        end
    end

    task automatic send(input logic [31:0] av, input logic [31:0] ce, input int kind, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = av;
        if (push) begin
            e.a = av; e.c_exp = ce; e.kind = kind; e.due = cyc + 5;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[19];
    int   p0;

    initial begin
        vecs[0]  = '{32'h3F80_0000, 32'h0000_0000, 0};
        vecs[1]  = '{32'h4000_0000, 32'h3F31_7217, 0};
        vecs[2]  = '{32'h3F00_0000, 32'hBF31_7217, 0};
        vecs[3]  = '{32'h4080_0000, 32'h3FB1_7217, 0};
        vecs[4]  = '{32'h3E80_0000, 32'hBFB1_7217, 0};
        vecs[5]  = '{32'h0000_0000, 32'hFF80_0000, 0};
        vecs[6]  = '{32'h8000_0000, 32'hFF80_0000, 0};
        vecs[7]  = '{32'hBF80_0000, 32'h7FC0_0000, 0};
        vecs[8]  = '{32'h7FC0_0001, 32'h7FC0_0000, 0};
        vecs[9]  = '{32'h7F80_0000, 32'h7F80_0000, 0};
        vecs[10] = '{32'hFF80_0000, 32'h7FC0_0000, 0};
        vecs[11] = '{32'h0000_0001, 32'hFF80_0000, 0};
        vecs[12] = '{32'hFFC0_0000, 32'h7FC0_0000, 0};
        vecs[13] = '{32'h7F7F_FFFF, 32'h42B1_7218, 1};
        vecs[14] = '{32'h0080_0000, 32'hC2AE_AC50, 1};
        vecs[15] = '{32'h3FC0_0000, 32'h0000_0000, 2};
        vecs[16] = '{32'h4040_0000, 32'h0000_0000, 2};
        vecs[17] = '{32'h3F80_0001, 32'h0000_0000, 2};
        vecs[18] = '{32'h4000_0000, 32'h3F31_7217, 0};

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.c !== 32'h0) begin
            errors++;
            $display("FAIL reset_state out_valid=%b c=%h required 0/00000000", bus.out_valid, bus.c);
        end
        reset = 1'b0;

        // single pulse of 1.0: exactly one result
        p0 = pulses;
        send(32'h3F80_0000, 32'h0000_0000, 0, 1'b1);
        idle();
        repeat (10) @(posedge clk);
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL single_pulse outputs=%0d required=1", pulses - p0);
        end
        drain();

        // directed table, back-to-back with mixed normal/special classes
        for (int i = 0; i < 19; i++)
            send(vecs[i].a, vecs[i].c_exp, vecs[i].kind, 1'b1);
        idle();
        drain();

        // reset while three operands are in flight
        p0 = pulses;
        send(32'h4000_0000, 32'h0, 0, 1'b0);
        send(32'h3F00_0000, 32'h0, 0, 1'b0);
        send(32'h4080_0000, 32'h0, 0, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.c !== 32'h0) begin
            errors++;
            $display("FAIL async_reset out_valid=%b c=%h required 0/00000000", bus.out_valid, bus.c);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL flushed_ops outputs=%0d required=0", pulses - p0);
        end
        send(32'h3F00_0000, 32'hBF31_7217, 0, 1'b1);
        idle();
        drain();

        // continuous random stream of positive normals
        for (int i = 0; i < 1000; i++)
            send({1'b0, 8'($urandom_range(254, 1)), 23'($urandom)}, 32'h0, 2, 1'b1);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
